// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - PC source encodings and alignment helpers shared by the PC unit
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_TRAP   = 2'b11
    } pc_src_e;

    // Low address bits that must be zero for a legal instruction fetch.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; overwrites oldest entry when full
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_push_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_nonempty,
    output logic            o_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic            r_underflow;
    logic [PW-1:0]   w_top_idx;
    logic            w_nonempty;
    logic            w_replace;

    // r_ptr addresses the next free slot, so the top lives one below it.
    assign w_top_idx   = r_ptr - PW'(1);
    assign w_nonempty  = (r_count != '0);
    assign w_replace   = i_push && i_pop && w_nonempty;
    assign o_top       = r_mem[w_top_idx];
    assign o_nonempty  = w_nonempty;
    assign o_underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (i_push) begin
            if (w_replace) begin
                r_mem[w_top_idx] <= i_push_data;
            end else begin
                r_mem[r_ptr] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= i_pop && !w_nonempty;
            if (w_replace) begin
                r_ptr   <= r_ptr;
                r_count <= r_count;
            end else if (i_push) begin
                r_ptr   <= r_ptr + PW'(1);
                r_count <= (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
            end else if (i_pop && w_nonempty) begin
                r_ptr   <= r_ptr - PW'(1);
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC select, alignment check and PC register; PC_RAS_EN adds a return-address stack
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              IMM_SHIFT = 2,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            PCWre,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] Address,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            misalign,
    output logic            ras_underflow
);
    logic [XLEN-1:0] r_addr;
    logic            r_misalign;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_branch;
    logic [XLEN-1:0] w_jump;
    logic [XLEN-1:0] w_next;
    logic            w_update;
    logic            w_ras_hit;
    logic [XLEN-1:0] w_ras_top;

    assign w_seq    = r_addr + XLEN'(INC);
    assign w_branch = r_addr + (immediate << IMM_SHIFT);
    assign w_jump   = {target[XLEN-1:1], 1'b0};
    // A trap must be taken even while the pipeline is stalled.
    assign w_update = PCWre || (PCSrc == PC_TRAP);

`ifdef PC_RAS_EN
    logic w_push;
    logic w_pop;
    logic w_ras_nonempty;

    assign w_push    = w_update && is_call && (PCSrc == PC_BRANCH || PCSrc == PC_JUMP);
    assign w_pop     = w_update && is_ret && (PCSrc == PC_JUMP);
    assign w_ras_hit = is_ret && (PCSrc == PC_JUMP) && w_ras_nonempty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (Reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_seq),
        .o_top       (w_ras_top),
        .o_nonempty  (w_ras_nonempty),
        .o_underflow (ras_underflow)
    );
`else
    logic w_unused_ras;

    assign w_unused_ras  = ^{is_call, is_ret};
    assign w_ras_hit     = 1'b0;
    assign w_ras_top     = '0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        w_next = w_seq;
        case (pc_src_e'(PCSrc))
            PC_SEQ:    w_next = w_seq;
            PC_BRANCH: w_next = w_branch;
            PC_JUMP:   w_next = w_ras_hit ? w_ras_top : w_jump;
            PC_TRAP:   w_next = trap_vec;
            default:   w_next = w_seq;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_addr     <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_update && is_misaligned(w_next[1:0]);
            if (w_update) begin
                r_addr <= w_next & ~XLEN'(ALIGN_MASK);
            end
        end
    end

    assign Address     = r_addr;
    assign pc_plus_inc = w_seq;
    assign misalign    = r_misalign;

endmodule
